// File: rtl/arov_dispatch_pkg.sv
// Shared types and constants for the accelerator job dispatcher.
//   acc_state_e : per-accelerator FSM state (IDLE, START, BUSY)
//   CNT_W       : width of the saturating busy-cycle counters
//   job_t       : job descriptor type at the default descriptor width
//   sat_inc     : saturating increment used by the busy counters
package arov_dispatch_pkg;

  localparam int CNT_W     = 32;
  localparam int JOB_W_DEF = 32;

  // Fixed encodings so the state can be compared against plain vectors
  // by older blocks that do not import the enum.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    BUSY  = ST_BUSY
  } acc_state_e;

  typedef logic [JOB_W_DEF-1:0] job_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/arov_acc_dispatcher_if.sv
// Bundle of the dispatcher's core-side and accelerator-side signals.
//   slave  : the dispatcher itself
//   master : the cores and accelerator tiles (or a testbench standing in)
// Core side : req_valid_i, req_ready_o, req_acc_id_i, req_job_i, evt_o, err_o
// Acc side  : acc_start_o, acc_job_o, acc_done_i, acc_busy_o, busy_cnt_o
interface arov_acc_dispatcher_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_ACC  = 8,
  parameter int JOB_W    = 32,
  parameter int ACC_ID_W = $clog2(NUM_ACC) + 1
);
  import arov_dispatch_pkg::*;

  logic [NUM_REQ-1:0]                req_valid_i;
  logic [NUM_REQ-1:0]                req_ready_o;
  logic [NUM_REQ-1:0][ACC_ID_W-1:0]  req_acc_id_i;
  logic [NUM_REQ-1:0][JOB_W-1:0]     req_job_i;
  logic [NUM_REQ-1:0]                evt_o;
  logic [NUM_REQ-1:0]                err_o;
  logic [NUM_ACC-1:0]                acc_start_o;
  logic [NUM_ACC-1:0][JOB_W-1:0]     acc_job_o;
  logic [NUM_ACC-1:0]                acc_done_i;
  logic [NUM_ACC-1:0]                acc_busy_o;
  logic [NUM_ACC-1:0][CNT_W-1:0]     busy_cnt_o;

  modport slave (
    input  req_valid_i, req_acc_id_i, req_job_i, acc_done_i,
    output req_ready_o, evt_o, err_o, acc_start_o, acc_job_o, acc_busy_o, busy_cnt_o
  );

  modport master (
    output req_valid_i, req_acc_id_i, req_job_i, acc_done_i,
    input  req_ready_o, evt_o, err_o, acc_start_o, acc_job_o, acc_busy_o, busy_cnt_o
  );

endinterface

// File: rtl/arov_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request vector
//   gnt_o        : one-hot grant (zero when nothing requests)
//   gnt_vld_o    : a grant is issued this cycle
//   gnt_idx_o    : index of the granted requester
// The priority pointer starts at 0 and moves to one past the winner only
// when a grant is issued.
module arov_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_vld_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  int               w_sum;

  // Scan from the pointer upward with wrap; first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IDX_W'(w_sum);
      if (!gnt_vld_o && req_i[w_idx]) begin
        gnt_vld_o    = 1'b1;
        gnt_o[w_idx] = 1'b1;
        gnt_idx_o    = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (gnt_vld_o) begin
      r_ptr <= (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/arov_acc_dispatcher.sv
// Job dispatcher sharing NUM_ACC accelerator tiles among NUM_REQ cores.
//   clk_i : sole clock
//   rst_i : asynchronous active-high reset; drops any job in flight
//   bus   : slave side of arov_acc_dispatcher_if (requests, events,
//           errors, accelerator start/job/done, busy flags, busy counters)
//
// Per-accelerator FSM:
//   state | meaning
//   IDLE  | free, may be granted to a core
//   START | one-cycle start pulse, descriptor valid on acc_job_o
//   BUSY  | running, waiting for acc_done_i
module arov_acc_dispatcher
  import arov_dispatch_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_ACC  = 8,
  parameter int JOB_W    = 32,
  parameter int ACC_ID_W = $clog2(NUM_ACC) + 1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  arov_acc_dispatcher_if.slave  bus
);

  localparam int                  REQ_IDX_W = $clog2(NUM_REQ);
  localparam logic [ACC_ID_W-1:0] ACC_LIMIT = ACC_ID_W'(NUM_ACC);

  acc_state_e           r_state [NUM_ACC];
  logic [JOB_W-1:0]     r_job   [NUM_ACC];
  logic [REQ_IDX_W-1:0] r_owner [NUM_ACC];
  logic [CNT_W-1:0]     r_cnt   [NUM_ACC];
  logic [NUM_REQ-1:0]   r_evt;
  logic [NUM_REQ-1:0]   r_err;

  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_oor;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_gnt_vld;
  logic [REQ_IDX_W-1:0] w_gnt_idx;
  logic [NUM_ACC-1:0]   w_dispatch;
  logic [NUM_REQ-1:0]   w_evt_nxt;

  // Out-of-range requests are always eligible so they can be rejected
  // promptly; a core waiting on a busy tile simply drops out of the race.
  always_comb begin
    w_elig = '0;
    w_oor  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      w_oor[r] = (bus.req_acc_id_i[r] >= ACC_LIMIT);
      if (bus.req_valid_i[r]) begin
        if (w_oor[r]) begin
          w_elig[r] = 1'b1;
        end else begin
          for (int a = 0; a < NUM_ACC; a++) begin
            if (bus.req_acc_id_i[r] == ACC_ID_W'(a) && r_state[a] == IDLE)
              w_elig[r] = 1'b1;
          end
        end
      end
    end
  end

  arov_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (w_elig),
    .gnt_o     (w_gnt),
    .gnt_vld_o (w_gnt_vld),
    .gnt_idx_o (w_gnt_idx)
  );

  assign bus.req_ready_o = w_gnt;

  always_comb begin
    w_dispatch = '0;
    for (int a = 0; a < NUM_ACC; a++) begin
      w_dispatch[a] = w_gnt_vld && !w_oor[w_gnt_idx] &&
                      (bus.req_acc_id_i[w_gnt_idx] == ACC_ID_W'(a));
    end
  end

  // Completions from several tiles owned by one core merge into one pulse.
  always_comb begin
    w_evt_nxt = '0;
    for (int a = 0; a < NUM_ACC; a++) begin
      if (r_state[a] == BUSY && bus.acc_done_i[a])
        w_evt_nxt[r_owner[a]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_evt <= '0;
      r_err <= '0;
      for (int a = 0; a < NUM_ACC; a++) begin
        r_state[a] <= IDLE;
        r_job[a]   <= '0;
        r_owner[a] <= '0;
        r_cnt[a]   <= '0;
      end
    end else begin
      r_evt <= w_evt_nxt;
      r_err <= w_gnt & w_oor;
      for (int a = 0; a < NUM_ACC; a++) begin
        if (r_state[a] != IDLE) r_cnt[a] <= sat_inc(r_cnt[a]);
        case (r_state[a])
          IDLE: begin
            if (w_dispatch[a]) begin
              r_state[a] <= START;
              r_job[a]   <= bus.req_job_i[w_gnt_idx];
              r_owner[a] <= w_gnt_idx;
            end
          end
          START:   r_state[a] <= BUSY;
          BUSY:    if (bus.acc_done_i[a]) r_state[a] <= IDLE;
          default: r_state[a] <= IDLE;
        endcase
      end
    end
  end

  for (genvar a = 0; a < NUM_ACC; a++) begin : g_acc_out
    assign bus.acc_start_o[a] = (r_state[a] == START);
    assign bus.acc_busy_o[a]  = (r_state[a] != IDLE);
    assign bus.acc_job_o[a]   = r_job[a];
    assign bus.busy_cnt_o[a]  = r_cnt[a];
  end

  assign bus.evt_o = r_evt;
  assign bus.err_o = r_err;

endmodule

// File: tb/tb_arov_acc_dispatcher.sv
// Self-checking bench for arov_acc_dispatcher: directed scenarios followed
// by random traffic, all compared against a cycle-count based job model.
module tb_arov_acc_dispatcher;

  localparam int NR = 4;
  localparam int NA = 8;
  localparam int JW = 32;
  localparam int IW = $clog2(NA) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arov_acc_dispatcher_if #(.NUM_REQ(NR), .NUM_ACC(NA), .JOB_W(JW), .ACC_ID_W(IW)) bus ();

  arov_acc_dispatcher #(.NUM_REQ(NR), .NUM_ACC(NA), .JOB_W(JW), .ACC_ID_W(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: a tile is either free or running a job that started
  // (pulsed) in a known cycle; done only counts after the start cycle.
  int          cyc;
  bit          m_run   [NA];
  int          m_start [NA];
  int          m_owner [NA];
  logic [31:0] m_job   [NA];
  longint      m_cnt   [NA];
  int          m_ptr;
  logic [NR-1:0] m_evt, m_err;

  function automatic void model_reset();
    cyc = 0; m_ptr = 0; m_evt = '0; m_err = '0;
    for (int a = 0; a < NA; a++) begin
      m_run[a] = 1'b0; m_start[a] = -10; m_owner[a] = 0; m_job[a] = '0; m_cnt[a] = 0;
    end
  endfunction

  task automatic clr_in();
    bus.req_valid_i  = '0;
    bus.req_acc_id_i = '0;
    bus.req_job_i    = '0;
    bus.acc_done_i   = '0;
  endtask

  // Called at a falling edge with inputs already driven; checks every
  // output, advances the model across the next rising edge.
  task automatic step();
    int            g, id;
    logic [NR-1:0] exp_rdy, nevt, nerr;
    logic [NA-1:0] exp_start, exp_busy;
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int r;
      r = (m_ptr + k) % NR;
      if (g < 0 && bus.req_valid_i[r]) begin
        id = int'(bus.req_acc_id_i[r]);
        if (id >= NA || !m_run[id]) g = r;
      end
    end
    exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
    for (int a = 0; a < NA; a++) begin
      exp_start[a] = m_run[a] && (m_start[a] == cyc);
      exp_busy[a]  = m_run[a];
    end
    chk_eq("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
    chk_eq("evt", 64'(bus.evt_o), 64'(m_evt));
    chk_eq("err", 64'(bus.err_o), 64'(m_err));
    chk_eq("acc_start", 64'(bus.acc_start_o), 64'(exp_start));
    chk_eq("acc_busy", 64'(bus.acc_busy_o), 64'(exp_busy));
    for (int a = 0; a < NA; a++) begin
      chk_eq($sformatf("acc_job[%0d]", a), 64'(bus.acc_job_o[a]), 64'(m_job[a]));
      chk_eq($sformatf("busy_cnt[%0d]", a), 64'(bus.busy_cnt_o[a]), 64'(m_cnt[a]));
    end
    nevt = '0; nerr = '0;
    for (int a = 0; a < NA; a++) begin
      if (m_run[a]) begin
        if (m_cnt[a] < 64'hFFFF_FFFF) m_cnt[a]++;
        if (bus.acc_done_i[a] && cyc > m_start[a]) begin
          m_run[a] = 1'b0;
          nevt[m_owner[a]] = 1'b1;
        end
      end
    end
    if (g >= 0) begin
      id = int'(bus.req_acc_id_i[g]);
      if (id < NA) begin
        m_run[id] = 1'b1; m_start[id] = cyc + 1; m_owner[id] = g;
        m_job[id] = bus.req_job_i[g];
      end else begin
        nerr[g] = 1'b1;
      end
      m_ptr = (g + 1) % NR;
    end
    m_evt = nevt; m_err = nerr; cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int gnt_q[$];
  int evt_q[$];
  logic [NR-1:0] pend;

  initial begin
    clr_in();
    model_reset();
    do_reset();
    chk_eq("rst_busy", 64'(bus.acc_busy_o), 64'd0);
    chk_eq("rst_cnt2", 64'(bus.busy_cnt_o[2]), 64'd0);
    step();

    // Single job: core 0 -> acc 2, done four cycles after the start pulse.
    bus.req_valid_i = 4'b0001; bus.req_acc_id_i[0] = IW'(2); bus.req_job_i[0] = 32'hA000_0000;
    #1 chk_eq("single_ready", 64'(bus.req_ready_o), 64'b0001);
    step();
    clr_in();
    chk_eq("single_start", 64'(bus.acc_start_o[2]), 64'd1);
    chk_eq("single_job", 64'(bus.acc_job_o[2]), 64'hA000_0000);
    repeat (4) step();
    bus.acc_done_i[2] = 1'b1;
    step();
    clr_in();
    chk_eq("single_evt", 64'(bus.evt_o), 64'b0001);
    chk_eq("single_cnt", 64'(bus.busy_cnt_o[2]), 64'd5);
    step();

    // Out-of-range target from core 2.
    bus.req_valid_i = 4'b0100; bus.req_acc_id_i[2] = IW'(NA);
    #1 chk_eq("oor_ready", 64'(bus.req_ready_o), 64'b0100);
    step();
    clr_in();
    chk_eq("oor_err", 64'(bus.err_o), 64'b0100);
    chk_eq("oor_start", 64'(bus.acc_start_o), 64'd0);
    step();

    // Contention: all cores on acc 1 from a fresh pointer.
    do_reset();
    gnt_q.delete(); evt_q.delete(); pend = '1;
    for (int i = 0; i < 60 && evt_q.size() < 4; i++) begin
      clr_in();
      bus.req_valid_i = pend;
      for (int r = 0; r < NR; r++) bus.req_acc_id_i[r] = IW'(1);
      bus.acc_done_i[1] = bus.acc_busy_o[1] & ~bus.acc_start_o[1];
      #1;
      for (int r = 0; r < NR; r++) if (bus.req_ready_o[r]) begin gnt_q.push_back(r); pend[r] = 1'b0; end
      step();
      for (int r = 0; r < NR; r++) if (bus.evt_o[r]) evt_q.push_back(r);
    end
    clr_in();
    chk_eq("cont_ngnt", 64'(gnt_q.size()), 64'd4);
    chk_eq("cont_nevt", 64'(evt_q.size()), 64'd4);
    for (int i = 0; i < gnt_q.size() && i < 4; i++) chk_eq($sformatf("cont_gnt%0d", i), 64'(gnt_q[i]), 64'(i));
    for (int i = 0; i < evt_q.size() && i < 4; i++) chk_eq($sformatf("cont_evt%0d", i), 64'(evt_q[i]), 64'(i));
    step();

    // Done collision: core 3 owns acc 4 and acc 5, both finish together.
    bus.req_valid_i = 4'b1000; bus.req_acc_id_i[3] = IW'(4); bus.req_job_i[3] = 32'h4444_0000;
    step();
    bus.req_acc_id_i[3] = IW'(5); bus.req_job_i[3] = 32'h5555_0000;
    step();
    clr_in();
    step();
    bus.acc_done_i[4] = 1'b1; bus.acc_done_i[5] = 1'b1;
    step();
    clr_in();
    chk_eq("coll_evt", 64'(bus.evt_o), 64'b1000);
    bus.acc_done_i[7] = 1'b1;
    step();
    clr_in();
    chk_eq("idle_done_evt", 64'(bus.evt_o), 64'd0);
    chk_eq("idle_done_busy", 64'(bus.acc_busy_o[7]), 64'd0);
    step();

    // Independence: core 0 waits on busy acc 0 while core 1 gets acc 3.
    bus.req_valid_i = 4'b0001; bus.req_acc_id_i[0] = IW'(0); bus.req_job_i[0] = 32'h0000_00A0;
    step();
    bus.req_valid_i = 4'b0011; bus.req_acc_id_i[1] = IW'(3); bus.req_job_i[1] = 32'h0000_03B1;
    #1 chk_eq("indep_ready", 64'(bus.req_ready_o), 64'b0010);
    step();
    bus.req_valid_i = 4'b0001;
    #1 chk_eq("indep_wait", 64'(bus.req_ready_o), 64'd0);
    step();
    bus.acc_done_i[0] = 1'b1;
    step();
    bus.acc_done_i[0] = 1'b0;
    #1 chk_eq("indep_regrant", 64'(bus.req_ready_o), 64'b0001);
    step();
    clr_in();
    step();

    // Reset while acc 6 is BUSY.
    bus.req_valid_i = 4'b0010; bus.req_acc_id_i[1] = IW'(6); bus.req_job_i[1] = 32'h1234_5678;
    step();
    clr_in();
    repeat (2) step();
    chk_eq("pre_rst_busy6", 64'(bus.acc_busy_o[6]), 64'd1);
    rst = 1'b1;
    #1;
    chk_eq("rst_busy6", 64'(bus.acc_busy_o[6]), 64'd0);
    chk_eq("rst_cnt6", 64'(bus.busy_cnt_o[6]), 64'd0);
    chk_eq("rst_job6", 64'(bus.acc_job_o[6]), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.acc_done_i[6] = 1'b1;
    step();
    clr_in();
    chk_eq("rst_no_evt", 64'(bus.evt_o), 64'd0);
    step();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < NR; r++) begin
        bus.req_valid_i[r]  = ($urandom_range(0, 1) == 1);
        bus.req_acc_id_i[r] = IW'($urandom_range(0, NA + 1));
        bus.req_job_i[r]    = $urandom;
      end
      for (int a = 0; a < NA; a++) bus.acc_done_i[a] = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
